freelist_ctrl: RTL
==================

FREELIST_CTRL -- requirements
Module: freelist_ctrl

Interface
REQ-001 SHALL have parameter PREG_NUM, default 64: total physical registers.
REQ-002 SHALL have parameter ARCH_NUM, default 32: architectural registers, identity-mapped to pregs 0..ARCH_NUM-1 at reset.
REQ-003 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port alloc_valid, input, 1: IRU requests one destination preg this cycle.
REQ-006 SHALL have port alloc_ready, output, 1: a free preg is available and no flush is active.
REQ-007 SHALL have port alloc_preg, output, `PREG_RANGE: preg granted when alloc_valid & alloc_ready.
REQ-008 SHALL have port commit_valid, input, 1: one instruction with need_to_wb retires.
REQ-009 SHALL have port commit_old_prd, input, `PREG_RANGE: preg freed by that retirement.
REQ-010 SHALL have port flush_valid, input, 1: squash all speculative allocations.
REQ-011 SHALL have port free_count, output, log2(PREG_NUM-ARCH_NUM)+1 bits: entries currently allocatable.

Function
REQ-012 SHALL store free pregs in a circular queue of DEPTH = PREG_NUM-ARCH_NUM entries, with spec head, arch head and tail pointers, each log2(DEPTH)+1 bits (MSB = wrap bit).
REQ-013 SHALL drive alloc_preg combinationally from queue[spec_head], for zero-cycle grant latency.
REQ-014 SHALL assert alloc_ready = (tail != spec_head) & ~flush_valid.
REQ-015 SHALL advance spec_head by 1 on alloc fire (alloc_valid & alloc_ready); if alloc_valid is high while alloc_ready is low, no state SHALL change.
REQ-016 SHALL, on commit_valid, write commit_old_prd to queue[tail], advance tail by 1, and advance arch_head by 1.
REQ-017 SHALL NOT bypass a same-cycle commit to alloc: when the queue is empty and a commit arrives, alloc_ready SHALL rise only in the next cycle.
REQ-018 SHALL, on flush_valid, load spec_head with the next-cycle arch_head (including a same-cycle commit increment); a same-cycle alloc SHALL NOT fire.
REQ-019 SHALL compute free_count = tail - spec_head, modulo 2^(pointer width), from registered pointers.
REQ-020 SHALL ignore commit_valid when the queue is full (tail - arch_head == DEPTH), and SHALL flag this in simulation with an assertion.
REQ-021 SHALL handle pointer wrap so that index bits wrap from DEPTH-1 to 0 and the wrap bit toggles.
REQ-022 SHALL process alloc fire and commit in the same cycle: spec_head+1, tail+1, arch_head+1, free_count unchanged.

Reset
REQ-023 SHALL, with reset_n low, asynchronously set queue[i] = ARCH_NUM+i, spec_head = arch_head = 0, and tail = DEPTH with the wrap bit set.
REQ-024 SHALL produce reset values of alloc_ready = 1, alloc_preg = ARCH_NUM (32), and free_count = DEPTH (32).
REQ-025 SHALL discard, on reset asserted mid-operation, all allocations, commits and flush state, with no partial pointer update surviving.

Structure
REQ-026 SHALL take `PREG_RANGE from the shared define header; the new macro FREELIST_DEPTH SHALL live in that same header.
REQ-027 SHALL be a single flat module with no sub-module; the queue SHALL be flops, not SRAM.

Verification
REQ-028 Reset release with no stimulus -> alloc_ready=1, alloc_preg=32, free_count=32.
REQ-029 32 back-to-back allocs -> grants 32..63 in order; alloc_ready=0 after the 32nd; free_count=0.
REQ-030 Queue empty, commit_old_prd=5 in cycle N -> alloc_ready=1 in N+1 with alloc_preg=5, and not in N.
REQ-031 Alloc 4 (32..35), commit 1 (old_prd=7), then flush -> spec_head=arch_head=1; next grants 33,34,35,...,63,7; free_count=32.
REQ-032 Flush, alloc_valid and commit in the same cycle -> no grant; spec_head = old arch_head + 1.
REQ-033 Run 100 alloc/commit pairs across the wrap -> free_count constant; each granted preg is unique among outstanding grants; no full-queue assertion fires.

Source files
------------

// File: rtl/freelist_ctrl_pkg.sv
// Shared definitions for the physical-register free list: the preg range and
// free-queue depth macros, plus the pointer helper used by the controller.
`ifndef FREELIST_CTRL_DEFINES
`define FREELIST_CTRL_DEFINES
`define PREG_RANGE ($clog2(PREG_NUM)-1):0
`define FREELIST_DEPTH (PREG_NUM-ARCH_NUM)
`endif

package freelist_ctrl_pkg;

   // True when a queue index sits on the last slot, so the next advance wraps.
   function automatic logic idx_at_end(input int unsigned idx, input int unsigned depth);
      return (idx == (depth - 32'd1));
   endfunction

endpackage

// File: rtl/freelist_ctrl_chk.sv
// Simulation checker for the free-list controller, bound into every instance.
module freelist_ctrl_chk (
   input logic clock,
   input logic reset_n,
   input logic commit_valid,
   input logic full_s
);

   // A retirement arriving while every preg is already queued is dropped; flag it.
   a_no_commit_when_full: assert property (@(posedge clock) disable iff (!reset_n)
      !(commit_valid && full_s));

endmodule

bind freelist_ctrl freelist_ctrl_chk u_freelist_ctrl_chk (
   .clock        (clock),
   .reset_n      (reset_n),
   .commit_valid (commit_valid),
   .full_s       (full_s)
);

// File: rtl/freelist_ctrl.sv
// Free-list controller: a flop-based circular queue of free physical registers
// with a speculative head (allocation), an architectural head (retirement) and
// a tail (freed pregs re-enter here). A flush rewinds the speculative head to
// the architectural head, returning every squashed allocation to the queue.
`ifndef FREELIST_CTRL_DEFINES
`define FREELIST_CTRL_DEFINES
`define PREG_RANGE ($clog2(PREG_NUM)-1):0
`define FREELIST_DEPTH (PREG_NUM-ARCH_NUM)
`endif

module freelist_ctrl
   import freelist_ctrl_pkg::*;
#(
   parameter int PREG_NUM = 64,
   parameter int ARCH_NUM = 32
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic                                 alloc_valid,
   output logic                                 alloc_ready,
   output logic [`PREG_RANGE]                   alloc_preg,
   input  logic                                 commit_valid,
   input  logic [`PREG_RANGE]                   commit_old_prd,
   input  logic                                 flush_valid,
   output logic [$clog2(`FREELIST_DEPTH):0]     free_count
);

   localparam int DEPTH  = `FREELIST_DEPTH;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int PTR_W  = IDX_W + 1;
   localparam int PREG_W = $clog2(PREG_NUM);

   logic [PREG_W-1:0] queue_r [DEPTH];
   logic [PTR_W-1:0]  spec_head_r;
   logic [PTR_W-1:0]  arch_head_r;
   logic [PTR_W-1:0]  tail_r;

   logic              alloc_ready_s;
   logic              alloc_fire_s;
   logic              commit_fire_s;
   logic              full_s;
   logic [PTR_W-1:0]  free_cnt_s;
   logic [PTR_W-1:0]  spec_head_nxt_s;
   logic [PTR_W-1:0]  arch_head_nxt_s;
   logic [PTR_W-1:0]  tail_nxt_s;

   // Advance a wrap-bit pointer: index rolls DEPTH-1 -> 0 and the wrap bit flips.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (idx_at_end(32'(p[IDX_W-1:0]), DEPTH)) begin
         r = {~p[PTR_W-1], {IDX_W{1'b0}}};
      end else begin
         r = p + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

   // Fire qualification, pointer advance and flush rewind for the next cycle.
   always_comb begin
      alloc_ready_s   = (tail_r != spec_head_r) && !flush_valid;
      alloc_fire_s    = alloc_valid && alloc_ready_s;
      free_cnt_s      = tail_r - spec_head_r;
      // arch_head trails tail by DEPTH by construction, so overflow is measured
      // against spec_head: every preg already queued means nothing can return.
      full_s          = (free_cnt_s == PTR_W'(DEPTH));
      commit_fire_s   = commit_valid && !full_s;
      tail_nxt_s      = tail_r;
      arch_head_nxt_s = arch_head_r;
      spec_head_nxt_s = spec_head_r;
      if (commit_fire_s) begin
         tail_nxt_s      = ptr_inc(tail_r);
         arch_head_nxt_s = ptr_inc(arch_head_r);
      end else begin
         tail_nxt_s      = tail_r;
         arch_head_nxt_s = arch_head_r;
      end
      if (flush_valid) begin
         spec_head_nxt_s = arch_head_nxt_s;
      end else if (alloc_fire_s) begin
         spec_head_nxt_s = ptr_inc(spec_head_r);
      end else begin
         spec_head_nxt_s = spec_head_r;
      end
   end

   // Pointer registers; reset leaves the whole queue free with tail one lap ahead.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         spec_head_r <= {PTR_W{1'b0}};
         arch_head_r <= {PTR_W{1'b0}};
         tail_r      <= {1'b1, {IDX_W{1'b0}}};
      end else begin
         spec_head_r <= spec_head_nxt_s;
         arch_head_r <= arch_head_nxt_s;
         tail_r      <= tail_nxt_s;
      end
   end

   // Queue storage; retired pregs are written at the tail slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            queue_r[i] <= PREG_W'(ARCH_NUM + i);
         end
      end else if (commit_fire_s) begin
         queue_r[tail_r[IDX_W-1:0]] <= commit_old_prd;
      end else begin
         queue_r[tail_r[IDX_W-1:0]] <= queue_r[tail_r[IDX_W-1:0]];
      end
   end

   assign alloc_ready = alloc_ready_s;
   assign alloc_preg  = queue_r[spec_head_r[IDX_W-1:0]];
   assign free_count  = free_cnt_s;

endmodule
